// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg: opcode/state enums and the add/sub overflow helper for alu_seq.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_OR   = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRA  = 4'b0101,
    ALU_ROL  = 4'b0110,
    ALU_ROR  = 4'b0111,
    ALU_NOT  = 4'b1000,
    ALU_SEQ  = 4'b1001,
    ALU_SLT  = 4'b1010,
    ALU_SLE  = 4'b1011,
    ALU_LD   = 4'b1100,
    ALU_ST   = 4'b1101,
    ALU_MULU = 4'b1110,
    ALU_DIVU = 4'b1111
  } aluop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Subtraction is addition of the inverted operand, so only its sign flips.
  function automatic logic add_sub_ovf(input logic a_msb, input logic b_msb,
                                       input logic r_msb, input logic is_sub);
    logic b_eff;
    b_eff = b_msb ^ is_sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
// ----------------------------------------------------------------------------
// alu_seq_if: request/result handshake bundle between decode and writeback.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMMW  = 4
) ();

  logic             in_valid;
  logic             in_ready;
  aluop_e           ctrl_aluop;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [IMMW-1:0]  imm;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rd;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             dz;

  modport master (
    output in_valid, ctrl_aluop, rs, rt, imm, out_ready,
    input  in_ready, out_valid, rd, zero, neg, ovf, dz
  );

  modport slave (
    input  in_valid, ctrl_aluop, rs, rt, imm, out_ready,
    output in_ready, out_valid, rd, zero, neg, ovf, dz
  );

endinterface

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ----------------------------------------------------------------------------
// alu_muldiv_iter: one-bit-per-cycle shift-add multiply / restoring divide.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_muldiv_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,      // 0: multiply, 1: divide
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   cnt;
  logic             is_div;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;

  // Multiply: hi:lo is the product with the multiplier shifting out of lo.
  // Divide: hi is the partial remainder, lo the dividend turning into quotient.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rem_sh   = {hi, lo[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd});
    rem_diff = rem_sh - {1'b0, opnd};
  end

  assign done = busy && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      is_div <= 1'b0;
      opnd   <= '0;
      lo     <= '0;
      hi     <= '0;
      dz     <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= SHW'(WIDTH - 1);
      is_div <= op;
      opnd   <= op ? b : a;
      lo     <= op ? a : b;
      hi     <= '0;
      dz     <= op && (b == '0);
    end else if (busy) begin
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        busy <= 1'b0;
      end
      if (is_div) begin
        hi <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        lo <= {lo[WIDTH-2:0], rem_ge};
      end else begin
        hi <= mul_sum[WIDTH:1];
        lo <= {mul_sum[0], lo[WIDTH-1:1]};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ----------------------------------------------------------------------------
// alu_seq: handshaked ALU with single-cycle ops and iterative MULU/DIVU.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMMW  = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  state_e           state;
  logic [WIDTH-1:0] rd_r;
  logic             zero_r;
  logic             neg_r;
  logic             ovf_r;
  logic             md_sel;
  logic             md_div;

  logic             accept;
  logic             is_md;
  logic [WIDTH-1:0] res;
  logic             res_ovf;

  logic             eng_busy;
  logic             eng_done;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] eng_hi;
  logic             eng_dz;
  logic             md_view;

  assign accept = bus.in_valid && (state == ST_IDLE);
  assign is_md  = (bus.ctrl_aluop == ALU_MULU) || (bus.ctrl_aluop == ALU_DIVU);

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (bus.ctrl_aluop)
      ALU_ADD: begin
        res     = bus.rs + bus.rt;
        res_ovf = add_sub_ovf(bus.rs[WIDTH-1], bus.rt[WIDTH-1], res[WIDTH-1], 1'b0);
      end
      ALU_SUB: begin
        res     = bus.rs - bus.rt;
        res_ovf = add_sub_ovf(bus.rs[WIDTH-1], bus.rt[WIDTH-1], res[WIDTH-1], 1'b1);
      end
      ALU_OR:                   res = bus.rs | bus.rt;
      ALU_AND:                  res = bus.rs & bus.rt;
      ALU_SLL:                  res = bus.rs << bus.imm;
      ALU_SRA:                  res = $signed(bus.rs) >>> bus.imm;
      ALU_ROL:                  res = {bus.rs[WIDTH-2:0], bus.rs[WIDTH-1]};
      ALU_ROR:                  res = {bus.rs[0], bus.rs[WIDTH-1:1]};
      ALU_NOT:                  res = ~bus.rs;
      ALU_SEQ, ALU_SLT, ALU_SLE: res = bus.rs - bus.rt;
      ALU_LD, ALU_ST:           res = bus.rs + {{(WIDTH-IMMW){1'b0}}, bus.imm};
      default:                  res = '0;
    endcase
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (accept && is_md),
    .op    (bus.ctrl_aluop == ALU_DIVU),
    .a     (bus.rs),
    .b     (bus.rt),
    .busy  (eng_busy),
    .done  (eng_done),
    .lo    (eng_lo),
    .hi    (eng_hi),
    .dz    (eng_dz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      rd_r   <= '0;
      zero_r <= 1'b0;
      neg_r  <= 1'b0;
      ovf_r  <= 1'b0;
      md_sel <= 1'b0;
      md_div <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            md_sel <= 1'b0;
            md_div <= (bus.ctrl_aluop == ALU_DIVU);
            if (is_md) begin
              state <= ST_BUSY;
            end else begin
              state  <= ST_DONE;
              rd_r   <= res;
              zero_r <= (res == '0);
              neg_r  <= res[WIDTH-1];
              ovf_r  <= res_ovf;
            end
          end
        end
        ST_BUSY: begin
          if (eng_done) begin
            state  <= ST_DONE;
            md_sel <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The engine's own registers hold the MULU/DIVU result once it goes idle.
  assign md_view = md_sel && !eng_busy;

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.rd        = md_view ? eng_lo : rd_r;
  assign bus.zero      = md_view ? (eng_lo == '0) : zero_r;
  assign bus.neg       = md_view ? eng_lo[WIDTH-1] : neg_r;
  assign bus.ovf       = md_view ? (!md_div && (eng_hi != '0)) : ovf_r;
  assign bus.dz        = md_view && eng_dz;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ----------------------------------------------------------------------------
// tb_alu_seq: directed and random checks of alu_seq against an arithmetic model.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 16;
  localparam int IMMW  = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(WIDTH), .IMMW(IMMW)) bus ();

  alu_seq #(.WIDTH(WIDTH), .IMMW(IMMW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] rd;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        dz;
    int          lat;
  } exp_t;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] im);
    exp_t        e;
    int unsigned ua;
    int unsigned ub;
    int          sa;
    int          sb;
    longint      full;
    longint      r;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    r = 0; e.ovf = 1'b0; e.dz = 1'b0; e.lat = 1;
    case (op)
      4'd0: begin full = sa + sb; r = ua + ub; e.ovf = (full > 32767) || (full < -32768); end
      4'd1: begin full = sa - sb; r = ua - ub; e.ovf = (full > 32767) || (full < -32768); end
      4'd2: r = ua | ub;
      4'd3: r = ua & ub;
      4'd4: r = ua << im;
      4'd5: r = sa >>> im;
      4'd6: r = (ua << 1) | (ua >> 15);
      4'd7: r = (ua >> 1) | ((ua & 1) << 15);
      4'd8: r = ~ua;
      4'd9, 4'd10, 4'd11: r = ua - ub;
      4'd12, 4'd13: r = ua + im;
      4'd14: begin full = longint'(ua) * longint'(ub); r = full; e.ovf = (full >> 16) != 0; e.lat = 17; end
      default: begin
        e.lat = 17;
        if (ub == 0) begin r = 65535; e.dz = 1'b1; end
        else r = ua / ub;
      end
    endcase
    e.rd   = r[15:0];
    e.zero = (e.rd == 16'h0);
    e.neg  = e.rd[15];
    return e;
  endfunction

  task automatic drive_req(input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [3:0] im);
    bus.in_valid   = 1'b1;
    bus.ctrl_aluop = aluop_e'(op);
    bus.rs         = a;
    bus.rt         = b;
    bus.imm        = im;
  endtask

  // Returns cycles from the accept edge until out_valid is seen (64 on timeout).
  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input exp_t e, input int lat);
    check_eq({tag, ".lat"}, lat, e.lat);
    check_eq({tag, ".rd"}, bus.rd, e.rd);
    check_eq({tag, ".flags"}, {bus.zero, bus.neg, bus.ovf, bus.dz}, {e.zero, e.neg, e.ovf, e.dz});
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] im);
    exp_t e;
    int   lat;
    e = model(op, a, b, im);
    check_eq({tag, ".in_ready"}, bus.in_ready, 1);
    drive_req(op, a, b, im);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.rs  = 16'($urandom);
    bus.rt  = 16'($urandom);
    bus.imm = 4'($urandom);
    wait_result(lat);
    check_result(tag, e, lat);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, ".back_idle"}, {bus.in_ready, bus.out_valid}, 2'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   lat;
    int   stray;

    rst = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.ctrl_aluop = ALU_ADD;
    bus.rs  = '0;
    bus.rt  = '0;
    bus.imm = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("reset.hs", {bus.in_ready, bus.out_valid}, 2'b10);
    check_eq("reset.rd", bus.rd, 0);
    check_eq("reset.flags", {bus.zero, bus.neg, bus.ovf, bus.dz}, 0);

    run_op("add_ovf", ALU_ADD, 16'h7FFF, 16'h0001, 4'h0);
    run_op("sub_zero", ALU_SUB, 16'h0005, 16'h0005, 4'h0);
    run_op("asr", ALU_SRA, 16'h8010, 16'h0000, 4'h4);
    run_op("rol", ALU_ROL, 16'h8001, 16'h0000, 4'h0);
    run_op("ld_addr", ALU_LD, 16'h00F0, 16'h0000, 4'hF);
    run_op("mul_hi", ALU_MULU, 16'h0100, 16'h0100, 4'h0);
    run_op("mul_lo", ALU_MULU, 16'h00FF, 16'h0003, 4'h0);
    run_op("div", ALU_DIVU, 16'd1000, 16'd7, 4'h0);
    run_op("div_zero", ALU_DIVU, 16'd5, 16'd0, 4'h0);
    run_op("div_big", ALU_DIVU, 16'hFFFF, 16'hFFFE, 4'h0);
    run_op("sub_ovf", ALU_SUB, 16'h8000, 16'h0001, 4'h0);

    // Backpressure: a completed MULU must hold while a new request waits.
    e = model(ALU_MULU, 16'h1234, 16'h0567, 4'h0);
    drive_req(ALU_MULU, 16'h1234, 16'h0567, 4'h0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(lat);
    check_result("bp_mul", e, lat);
    drive_req(ALU_ADD, 16'h0001, 16'h0002, 4'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq("bp_hold.rd", bus.rd, e.rd);
      check_eq("bp_hold.flags", {bus.zero, bus.neg, bus.ovf, bus.dz}, {e.zero, e.neg, e.ovf, e.dz});
      check_eq("bp_hold.hs", {bus.in_ready, bus.out_valid}, 2'b01);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq("bp_release.hs", {bus.in_ready, bus.out_valid}, 2'b10);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_eq("bp_next.valid", bus.out_valid, 1);
    check_eq("bp_next.rd", bus.rd, 16'h0003);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Reset in the middle of a DIVU abandons it.
    drive_req(ALU_DIVU, 16'd1000, 16'd7, 4'h0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_mid.hs", {bus.in_ready, bus.out_valid}, 2'b10);
    check_eq("rst_mid.rd", bus.rd, 0);
    check_eq("rst_mid.flags", {bus.zero, bus.neg, bus.ovf, bus.dz}, 0);
    stray = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) stray++;
    end
    check_eq("rst_mid.no_stale", stray, 0);
    run_op("post_rst", ALU_OR, 16'hA500, 16'h005A, 4'h0);

    for (int i = 0; i < 80; i++) begin
      logic [3:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle 16-bit datapath ALU.
- Keeps the existing 14 R/S/B/L-type operations unchanged.
- Adds two multi-cycle operations: iterative unsigned multiply and unsigned divide.
- Registers result and flags behind a valid/ready interface. Sits between the decode/register-read stage and writeback; the pipeline stalls on in_ready.

Parameters:
- WIDTH, 16, datapath width in bits; must be at least 8 and even.
- IMMW, 4, unsigned immediate width; must be at most clog2(WIDTH).
- SHW, clog2(WIDTH), derived shift-amount width; not overridable.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- ctrl_aluop  in  4  operation select (alu_pkg::aluop_e)
- rs  in  WIDTH  source 1
- rt  in  WIDTH  source 2
- imm  in  IMMW  unsigned immediate
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- rd  out  WIDTH  result
- zero  out  1  rd == 0
- neg  out  1  rd[WIDTH-1]
- ovf  out  1  signed overflow (ADD/SUB); nonzero high half (MUL)
- dz  out  1  divide by zero (DIVU only)

Behaviour:
- Reset: state=IDLE; rd=0, zero=0, neg=0, ovf=0, dz=0, out_valid=0; in_ready=1 from the first cycle after reset. Reset mid-operation abandons the operation silently and produces no output.
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: a request is accepted when in_valid & in_ready. Operands and opcode are latched on the accept edge. Inputs are ignored at all other times.
- Single-cycle ops (0000-1101): result and flags are computed from the latched operands. IDLE->DONE on the accept edge, so out_valid rises 1 cycle after accept.
- Single-cycle op semantics, all modulo 2^WIDTH:
  - 0000 add; 0001 sub; 0010 or; 0011 and.
  - 0100 shift left by imm; 0101 arithmetic shift right by imm.
  - 0110 rotate left by 1; 0111 rotate right by 1; 1000 bitwise not.
  - 1001, 1010, 1011: rs-rt (flags only).
  - 1100, 1101: rs + zero-extended imm.
- 1110 MULU: shift-add over WIDTH iterations. rd = low WIDTH bits of rs*rt; ovf = (high WIDTH bits != 0).
- 1111 DIVU: restoring division over WIDTH iterations. rd = floor(rs/rt).
  - If rt==0: rd = all ones, dz=1, ovf=0. Still takes the full WIDTH iterations.
- Multi-cycle timing: IDLE->BUSY on accept. An iteration counter loads WIDTH-1 and decrements once per cycle; BUSY->DONE when it reaches 0. out_valid rises exactly WIDTH+1 cycles after accept (17 cycles at WIDTH=16).
- DONE: rd and all flags hold stable while out_valid & !out_ready. DONE->IDLE on out_valid & out_ready. The earliest next accept is the cycle after the handshake; there is no overlap.
- Flags:
  - zero and neg are derived from the final rd for all ops.
  - ovf: ADD/SUB use the sign rule (operands same sign and result differs for add; operands differ in sign and result sign differs from rs for sub). MULU as above. 0 for all other ops.
  - dz is 0 except for DIVU with rt==0.
- in_valid while BUSY or DONE: no effect. The requester must hold the request until in_ready.

Decomposition:
- alu_pkg holds aluop_e (4-bit enum, 16 named codes), the state_e enum, and a helper function computing the add/sub overflow.
- One natural sub-module, alu_muldiv_iter: an iterative unsigned multiply/divide engine.
  - Interface: start, op, a, b in; busy, done, lo, hi, dz out.
  - Owns the accumulator, shift registers and iteration counter. The top level owns the FSM, the single-cycle ops and the flags.

Test Plan (WIDTH=16, IMMW=4):
- ADD 0x7FFF + 0x0001 accepted at cycle N -> out_valid at N+1; rd=0x8000, neg=1, ovf=1, zero=0. SUB 0x0005-0x0005 -> rd=0, zero=1, ovf=0.
- ASR rs=0x8010, imm=4 -> rd=0xF801, neg=1. ROL 0x8001 -> 0x0003. LD-addr 0x00F0 + imm 0xF -> 0x00FF.
- MULU 0x0100*0x0100 -> out_valid at N+17; rd=0x0000, ovf=1, zero=1. MULU 0x00FF*0x0003 -> rd=0x02FD, ovf=0.
- DIVU 1000/7 -> rd=142 at N+17. DIVU 5/0 -> rd=0xFFFF, dz=1, neg=1.
- Backpressure: hold out_ready=0 for 5 cycles after a MULU completes -> rd and flags stable, in_ready=0, and a new in_valid is ignored. Raise out_ready -> IDLE the next cycle; the new request is accepted one cycle later.
- Assert rst during BUSY cycle 8 of a DIVU -> the next cycle has out_valid=0, in_ready=1, rd=0, and all flags 0; no stale result appears afterwards.
